// File: rtl/dm_arb_pkg.sv
// Shared encodings and sizing helpers for the dm_arbiter data-memory arbiter.
package dm_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CPU_OWN = 2'd1,
    DBG_OWN = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    NONE = 2'd0,
    CPU  = 2'd1,
    DBG  = 2'd2
  } owner_t;

  // Enough bits to hold the saturation value itself.
  function automatic int starve_cnt_width(input int max_cnt);
    return (max_cnt < 1) ? 1 : $clog2(max_cnt + 1);
  endfunction

endpackage

// File: rtl/dm_arb_starve_cnt.sv
// Saturating count of consecutive denied debug-request cycles; starve_hit
// forces the next debug grant over the CPU.
module dm_arb_starve_cnt
  import dm_arb_pkg::*;
#(
  parameter int STARVE_MAX = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic dbg_req,
  input  logic dbg_gnt,
  output logic starve_hit
);

  localparam int CNT_W = starve_cnt_width(STARVE_MAX);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || dbg_gnt || !dbg_req) begin
      cnt <= '0;
    end else if (cnt != CNT_MAX) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign starve_hit = (cnt == CNT_MAX);

endmodule

// File: rtl/dm_arbiter.sv
// Two-port CPU/debug arbiter for the shared data memory, fixed CPU priority with
// lock ownership. Define DM_ARB_STARVE_EN to compile in the debug starvation guard.
module dm_arbiter
  import dm_arb_pkg::*;
#(
  parameter int ADDR_W     = 7,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_lock,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  input  logic              dbg_req,
  input  logic              dbg_lock,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic              cpu_gnt,
  output logic              dbg_gnt,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              dbg_rvalid,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic              mem_wea,
  output logic [ADDR_W-1:0] mem_addra,
  output logic [ADDR_W-1:0] mem_addrb,
  output logic [DATA_W-1:0] mem_dina,
  input  logic [DATA_W-1:0] mem_doutb
);

  state_t state, state_nxt;
  owner_t owner_p0;
  logic   starve_hit;
  logic   cpu_rd_p0;
  logic   dbg_rd_p0;

`ifdef DM_ARB_STARVE_EN
  dm_arb_starve_cnt #(
    .STARVE_MAX(STARVE_MAX)
  ) u_starve_cnt (
    .clk       (clk),
    .rst       (rst),
    .dbg_req   (dbg_req),
    .dbg_gnt   (dbg_gnt),
    .starve_hit(starve_hit)
  );
`else
  assign starve_hit = 1'b0;
`endif

  // A starved debug request outranks the CPU even while the CPU holds a lock,
  // so CPU_OWN needs no special handling beyond the plain priority.
  function automatic owner_t arbitrate(input logic c_req, input logic d_req,
                                       input logic hit);
    if (hit && d_req) return DBG;
    if (c_req)        return CPU;
    if (d_req)        return DBG;
    return NONE;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = IDLE;
    case (owner_p0)
      CPU:     if (cpu_lock) state_nxt = CPU_OWN;
      DBG:     if (dbg_lock) state_nxt = DBG_OWN;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    owner_p0  = NONE;
    cpu_gnt   = 1'b0;
    dbg_gnt   = 1'b0;
    mem_wea   = 1'b0;
    mem_addra = '0;
    mem_addrb = '0;
    mem_dina  = '0;
    if (!rst) begin
      case (state)
        DBG_OWN: owner_p0 = dbg_req ? DBG : arbitrate(cpu_req, dbg_req, starve_hit);
        default: owner_p0 = arbitrate(cpu_req, dbg_req, starve_hit);
      endcase
    end
    case (owner_p0)
      CPU: begin
        cpu_gnt   = 1'b1;
        mem_wea   = cpu_we;
        mem_addra = cpu_addr;
        mem_dina  = cpu_wdata;
      end
      DBG: begin
        dbg_gnt   = 1'b1;
        mem_wea   = dbg_we;
        mem_addra = dbg_addr;
        mem_dina  = dbg_wdata;
      end
      default: ;
    endcase
    mem_addrb = mem_addra;
  end

  assign cpu_rd_p0 = (owner_p0 == CPU) && !cpu_we;
  assign dbg_rd_p0 = (owner_p0 == DBG) && !dbg_we;

  // p0 -> p1: capture asynchronous read data for the winning read beat.
  always_ff @(posedge clk) begin
    if (rst) begin
      cpu_rvalid <= 1'b0;
      dbg_rvalid <= 1'b0;
      cpu_rdata  <= '0;
      dbg_rdata  <= '0;
    end else begin
      cpu_rvalid <= cpu_rd_p0;
      dbg_rvalid <= dbg_rd_p0;
      if (cpu_rd_p0) cpu_rdata <= mem_doutb;
      if (dbg_rd_p0) dbg_rdata <= mem_doutb;
    end
  end

endmodule

// File: tb/tb_dm_arbiter.sv
// Self-checking bench for dm_arbiter: directed scenarios plus randomized traffic
// against a behavioural model of ownership, starvation and memory contents.
module tb_dm_arbiter;

  localparam int ADDR_W     = 7;
  localparam int DATA_W     = 32;
  localparam int STARVE_MAX = 4;
  localparam int DEPTH      = 1 << ADDR_W;
`ifdef DM_ARB_STARVE_EN
  localparam bit STARVE_ON = 1'b1;
`else
  localparam bit STARVE_ON = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic              cpu_req, cpu_lock, cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              dbg_req, dbg_lock, dbg_we;
  logic [ADDR_W-1:0] dbg_addr;
  logic [DATA_W-1:0] dbg_wdata;
  logic              cpu_gnt, dbg_gnt, cpu_rvalid, dbg_rvalid, mem_wea;
  logic [DATA_W-1:0] cpu_rdata, dbg_rdata, mem_dina, mem_doutb;
  logic [ADDR_W-1:0] mem_addra, mem_addrb;
  logic              init_mem;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  dm_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_MAX(STARVE_MAX)
  ) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_lock(cpu_lock), .cpu_we(cpu_we),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .dbg_req(dbg_req), .dbg_lock(dbg_lock), .dbg_we(dbg_we),
    .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .cpu_gnt(cpu_gnt), .dbg_gnt(dbg_gnt),
    .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata),
    .mem_wea(mem_wea), .mem_addra(mem_addra), .mem_addrb(mem_addrb),
    .mem_dina(mem_dina), .mem_doutb(mem_doutb)
  );

  function automatic logic [DATA_W-1:0] init_val(input int a);
    return 32'hA500_0000 | DATA_W'(a);
  endfunction

  // Memory attached to the DUT: write port A on the clock, async read port B.
  logic [DATA_W-1:0] mem [DEPTH];
  assign mem_doutb = mem[mem_addrb];
  always @(posedge clk) begin
    if (init_mem) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= init_val(i);
    end else if (mem_wea) begin
      mem[mem_addra] <= mem_dina;
    end
  end

  // Reference model: lock owner (0 none, 1 cpu, 2 dbg), denied-cycle count,
  // shadow memory and the read return expected one cycle after a read grant.
  int                ref_lock;
  int                ref_starve;
  int                exp_win;
  logic              starved;
  logic [DATA_W-1:0] ref_mem [DEPTH];
  logic              exp_cpu_rv, exp_dbg_rv;
  logic [DATA_W-1:0] exp_cpu_rd, exp_dbg_rd;

  always_comb begin
    starved = STARVE_ON && (ref_starve >= STARVE_MAX);
    exp_win = 0;
    if (rst)                           exp_win = 0;
    else if (ref_lock == 2 && dbg_req) exp_win = 2;
    else if (starved && dbg_req)       exp_win = 2;
    else if (cpu_req)                  exp_win = 1;
    else if (dbg_req)                  exp_win = 2;
  end

  always @(posedge clk) begin
    if (init_mem) begin
      for (int i = 0; i < DEPTH; i++) ref_mem[i] <= init_val(i);
    end
    if (rst) begin
      ref_lock   <= 0;
      ref_starve <= 0;
      exp_cpu_rv <= 1'b0;
      exp_dbg_rv <= 1'b0;
      exp_cpu_rd <= '0;
      exp_dbg_rd <= '0;
    end else begin
      exp_cpu_rv <= 1'b0;
      exp_dbg_rv <= 1'b0;
      ref_lock   <= 0;
      if (exp_win == 1) begin
        if (cpu_we) ref_mem[cpu_addr] <= cpu_wdata;
        else begin exp_cpu_rv <= 1'b1; exp_cpu_rd <= ref_mem[cpu_addr]; end
        if (cpu_lock) ref_lock <= 1;
      end else if (exp_win == 2) begin
        if (dbg_we) ref_mem[dbg_addr] <= dbg_wdata;
        else begin exp_dbg_rv <= 1'b1; exp_dbg_rd <= ref_mem[dbg_addr]; end
        if (dbg_lock) ref_lock <= 2;
      end
      if (dbg_req && exp_win != 2)
        ref_starve <= (ref_starve < STARVE_MAX) ? ref_starve + 1 : STARVE_MAX;
      else
        ref_starve <= 0;
    end
  end

  task automatic idle_inputs();
    cpu_req = 1'b0; cpu_lock = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    dbg_req = 1'b0; dbg_lock = 1'b0; dbg_we = 1'b0; dbg_addr = '0; dbg_wdata = '0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; init_mem = 1'b1;
    idle_inputs();
    cpu_req = 1'b1; dbg_req = 1'b1;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      n_checks++;
      if ({cpu_gnt, dbg_gnt, mem_wea} !== 3'b000)
        $display("FAIL reset_gnt: got %b required 000", {cpu_gnt, dbg_gnt, mem_wea});
      else n_pass++;
      n_checks++;
      if ({cpu_rvalid, dbg_rvalid, cpu_rdata, dbg_rdata} !== '0)
        $display("FAIL reset_rd: got %b/%b %h %h required zeros",
                 cpu_rvalid, dbg_rvalid, cpu_rdata, dbg_rdata);
      else n_pass++;
      next_cycle();
      init_mem = 1'b0;
    end
    rst = 1'b0;
    idle_inputs();
  endtask

  task automatic test_cpu_write_read();
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 7'h05; cpu_wdata = 32'hDEAD_BEEF;
    @(negedge clk);
    n_checks++;
    if ({cpu_gnt, mem_wea, mem_addra, mem_dina} !== {1'b1, 1'b1, 7'h05, 32'hDEAD_BEEF})
      $display("FAIL cpu_write: got gnt=%b we=%b a=%h d=%h required 1 1 05 deadbeef",
               cpu_gnt, mem_wea, mem_addra, mem_dina);
    else n_pass++;
    next_cycle();
    cpu_we = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({cpu_gnt, mem_wea, mem_addrb} !== {1'b1, 1'b0, 7'h05})
      $display("FAIL cpu_read_gnt: got gnt=%b we=%b ab=%h required 1 0 05",
               cpu_gnt, mem_wea, mem_addrb);
    else n_pass++;
    next_cycle();
    cpu_req = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({cpu_rvalid, cpu_rdata} !== {1'b1, 32'hDEAD_BEEF})
      $display("FAIL cpu_raw: got rvalid=%b data=%h required 1 deadbeef", cpu_rvalid, cpu_rdata);
    else n_pass++;
    next_cycle();
  endtask

  task automatic test_both_read();
    cpu_req = 1'b1; cpu_addr = 7'h01;
    dbg_req = 1'b1; dbg_addr = 7'h02;
    @(negedge clk);
    n_checks++;
    if ({cpu_gnt, dbg_gnt} !== 2'b10)
      $display("FAIL both_read_prio: got %b required 10", {cpu_gnt, dbg_gnt});
    else n_pass++;
    next_cycle();
    cpu_req = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({dbg_gnt, cpu_rvalid, cpu_rdata} !== {1'b1, 1'b1, init_val(1)})
      $display("FAIL both_read_cpu: got gnt=%b rv=%b d=%h required 1 1 %h",
               dbg_gnt, cpu_rvalid, cpu_rdata, init_val(1));
    else n_pass++;
    next_cycle();
    dbg_req = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({dbg_rvalid, dbg_rdata} !== {1'b1, init_val(2)})
      $display("FAIL both_read_dbg: got rv=%b d=%h required 1 %h", dbg_rvalid, dbg_rdata, init_val(2));
    else n_pass++;
    next_cycle();
  endtask

  task automatic test_starvation();
    int first = 0;
    cpu_req = 1'b1; cpu_addr = 7'h20;
    dbg_req = 1'b1; dbg_addr = 7'h10;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (dbg_gnt && first == 0) begin
        first = c;
        n_checks++;
        if (cpu_gnt !== 1'b0) $display("FAIL starve_excl: got cpu_gnt=%b required 0", cpu_gnt);
        else n_pass++;
      end
      next_cycle();
    end
    n_checks++;
    if (first != (STARVE_ON ? STARVE_MAX + 1 : 0))
      $display("FAIL starve_cycle: got first dbg grant cycle %0d required %0d",
               first, STARVE_ON ? STARVE_MAX + 1 : 0);
    else n_pass++;
    idle_inputs();
    next_cycle();
  endtask

  task automatic test_dbg_burst();
    dbg_req = 1'b1; dbg_lock = 1'b1; dbg_addr = 7'h30;
    for (int beat = 1; beat <= 4; beat++) begin
      @(negedge clk);
      n_checks++;
      if ({cpu_gnt, dbg_gnt} !== ((beat <= 3) ? 2'b01 : 2'b10))
        $display("FAIL dbg_burst_beat%0d: got %b required %b", beat, {cpu_gnt, dbg_gnt},
                 (beat <= 3) ? 2'b01 : 2'b10);
      else n_pass++;
      if (beat >= 2) begin
        n_checks++;
        if ({dbg_rvalid, dbg_rdata} !== {1'b1, init_val(32'h30 + beat - 2)})
          $display("FAIL dbg_burst_data%0d: got rv=%b d=%h required 1 %h", beat,
                   dbg_rvalid, dbg_rdata, init_val(32'h30 + beat - 2));
        else n_pass++;
      end
      next_cycle();
      cpu_req  = 1'b1; cpu_addr = 7'h40;
      dbg_addr = dbg_addr + 7'd1;
      if (beat == 2) dbg_lock = 1'b0;
    end
    idle_inputs();
    next_cycle();
  endtask

  task automatic test_reset_mid_burst();
    cpu_req = 1'b1; cpu_lock = 1'b1; cpu_addr = 7'h08;
    for (int beat = 1; beat <= 2; beat++) begin
      @(negedge clk);
      n_checks++;
      if (cpu_gnt !== 1'b1) $display("FAIL rst_burst_beat%0d: got %b required 1", beat, cpu_gnt);
      else n_pass++;
      next_cycle();
    end
    rst = 1'b1; dbg_req = 1'b1; dbg_addr = 7'h09;
    @(negedge clk);
    n_checks++;
    if ({cpu_gnt, dbg_gnt, mem_wea} !== 3'b000)
      $display("FAIL rst_burst_hold: got %b required 000", {cpu_gnt, dbg_gnt, mem_wea});
    else n_pass++;
    next_cycle();
    rst = 1'b0; cpu_req = 1'b0; cpu_lock = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({cpu_rvalid, cpu_gnt, dbg_gnt} !== 3'b001)
      $display("FAIL rst_burst_after: got rv/cg/dg=%b required 001", {cpu_rvalid, cpu_gnt, dbg_gnt});
    else n_pass++;
    next_cycle();
    idle_inputs();
    next_cycle();
  endtask

  task automatic test_random();
    logic              e_we;
    logic [ADDR_W-1:0] e_addr;
    logic [DATA_W-1:0] e_din;
    for (int c = 0; c < 400; c++) begin
      rst       = ($urandom_range(0, 39) == 0);
      cpu_req   = ($urandom_range(0, 3) != 0);
      cpu_lock  = ($urandom_range(0, 2) == 0);
      cpu_we    = ($urandom_range(0, 2) == 0);
      cpu_addr  = ADDR_W'($urandom_range(0, 15));
      cpu_wdata = $urandom;
      dbg_req   = ($urandom_range(0, 3) != 0);
      dbg_lock  = ($urandom_range(0, 2) == 0);
      dbg_we    = ($urandom_range(0, 2) == 0);
      dbg_addr  = ADDR_W'($urandom_range(0, 15));
      dbg_wdata = $urandom;
      @(negedge clk);
      e_we = 1'b0; e_addr = '0; e_din = '0;
      if (exp_win == 1) begin e_we = cpu_we; e_addr = cpu_addr; e_din = cpu_wdata; end
      if (exp_win == 2) begin e_we = dbg_we; e_addr = dbg_addr; e_din = dbg_wdata; end
      n_checks++;
      if ({cpu_gnt, dbg_gnt} !== {exp_win == 1, exp_win == 2})
        $display("FAIL rand_gnt[%0d]: got %b required %b", c, {cpu_gnt, dbg_gnt},
                 {exp_win == 1, exp_win == 2});
      else n_pass++;
      n_checks++;
      if ({mem_wea, mem_addra, mem_addrb, mem_dina} !== {e_we, e_addr, e_addr, e_din})
        $display("FAIL rand_bus[%0d]: got %b %h %h %h required %b %h %h %h", c,
                 mem_wea, mem_addra, mem_addrb, mem_dina, e_we, e_addr, e_addr, e_din);
      else n_pass++;
      n_checks++;
      if ({cpu_rvalid, dbg_rvalid, cpu_rdata, dbg_rdata} !==
          {exp_cpu_rv, exp_dbg_rv, exp_cpu_rd, exp_dbg_rd})
        $display("FAIL rand_rd[%0d]: got %b%b %h %h required %b%b %h %h", c,
                 cpu_rvalid, dbg_rvalid, cpu_rdata, dbg_rdata,
                 exp_cpu_rv, exp_dbg_rv, exp_cpu_rd, exp_dbg_rd);
      else n_pass++;
      next_cycle();
    end
    rst = 1'b0;
    idle_inputs();
    next_cycle();
  endtask

  initial begin
    rst = 1'b1;
    init_mem = 1'b1;
    idle_inputs();
    test_reset();
    test_cpu_write_read();
    test_both_read();
    test_starvation();
    test_dbg_burst();
    test_reset_mid_burst();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
